// File: rtl/imm_encoder.sv
// imm_encoder: packs a two's-complement immediate into a 16-bit instruction
// template according to the opcode in bits [2:0], and queues the result in a
// 2-entry output FIFO with valid/ready handshakes on both sides.
// Optional feature: define IMM_RANGE_CHECK_EN to enable immediate range
// checking (out_range_err, err_count, err_sticky). Without it, immediates are
// silently truncated and those outputs are tied to 0.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_fields,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instr,
  output logic             out_range_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count,
  output logic             err_sticky,
  input  logic             clr_err
);

  logic [15:0] enc_word;
  logic        range_err;
  logic        push;
  logic        pop;

  // FIFO storage: {instr, range_err}
  logic [16:0] mem [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;
  logic        live;   // low during reset and until the first clock after it

  // Place the immediate bits into the template according to the opcode
  always_comb begin
    enc_word = in_fields;
    case (in_fields[2:0])
      3'b000: enc_word[15:12] = in_imm[3:0];
      3'b001: begin
        enc_word[15]   = in_imm[5];
        enc_word[13:9] = in_imm[4:0];
      end
      3'b010: enc_word[15:9] = in_imm[6:0];
      3'b011: enc_word = in_fields;
      3'b100, 3'b101: begin
        enc_word[15:12] = in_imm[6:3];
        enc_word[5:3]   = in_imm[2:0];
      end
      3'b110, 3'b111: enc_word[15:6] = in_imm[9:0];
      default: enc_word = in_fields;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate fits when every bit above the field's top bit equals that top bit
  always_comb begin
    range_err = 1'b0;
    case (in_fields[2:0])
      3'b000: range_err = ~((&in_imm[15:3]) | ~(|in_imm[15:3]));
      3'b001: range_err = ~((&in_imm[15:5]) | ~(|in_imm[15:5]));
      3'b010: range_err = ~((&in_imm[15:6]) | ~(|in_imm[15:6]));
      3'b011: range_err = |in_imm;
      3'b100, 3'b101: range_err = ~((&in_imm[15:6]) | ~(|in_imm[15:6]));
      3'b110, 3'b111: range_err = ~((&in_imm[15:9]) | ~(|in_imm[15:9]));
      default: range_err = 1'b0;
    endcase
  end

  // Saturating error counter and sticky flag; a same-cycle error wins over clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_count  <= (push && range_err) ? 8'd1 : 8'd0;
      err_sticky <= push && range_err;
    end else if (push && range_err) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      err_sticky <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clr_err, in_imm[15:10]};
  assign range_err     = 1'b0;
  assign err_count     = '0;
  assign err_sticky    = 1'b0;
`endif

  assign in_ready  = live && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr     = out_valid ? mem[rptr][16:1] : '0;
  assign out_range_err = out_valid & mem[rptr][0];

  // FIFO pointers, occupancy and the post-reset enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO data; contents are only observed through the out_valid gate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wptr] <= {enc_word, range_err};
    end
  end

  // Accepted-request counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) enc_count <= '0;
    else if (push) enc_count <= enc_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_imm_encoder;

  localparam int CNT_W = 16;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_fields;
  logic [15:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_instr;
  logic             out_range_err;
  logic [CNT_W-1:0] enc_count;
  logic [7:0]       err_count;
  logic             err_sticky;
  logic             clr_err;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fields(in_fields), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_range_err(out_range_err),
    .enc_count(enc_count), .err_count(err_count),
    .err_sticky(err_sticky), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [16:0] q[$];
  int          m_enc;
  int          m_err;
  bit          m_sticky;
  bit          m_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Immediate field width per opcode (0 = no field)
  function automatic int ref_width(input logic [2:0] opc);
    case (opc)
      3'd0: return 4;
      3'd1: return 6;
      3'd2: return 7;
      3'd3: return 0;
      3'd4, 3'd5: return 7;
      default: return 10;
    endcase
  endfunction

  // Out of range when the signed value exceeds the field's representable range
  function automatic bit ref_err(input logic [15:0] f, input logic [15:0] imm);
    int w;
    int v;
    int lim;
    w = ref_width(f[2:0]);
    v = int'($signed(imm));
    if (w == 0) return v != 0;
    lim = 1 << (w - 1);
    return (v < -lim) || (v > lim - 1);
  endfunction

  // Bit placement table: dst[i] is the instruction bit receiving imm bit i
  function automatic logic [15:0] ref_encode(input logic [15:0] f, input logic [15:0] imm);
    int dst[16];
    logic [15:0] w;
    w = f;
    for (int i = 0; i < 16; i++) dst[i] = -1;
    case (f[2:0])
      3'd0: for (int i = 0; i < 4; i++) dst[i] = 12 + i;
      3'd1: begin
        for (int i = 0; i < 5; i++) dst[i] = 9 + i;
        dst[5] = 15;
      end
      3'd2: for (int i = 0; i < 7; i++) dst[i] = 9 + i;
      3'd3: ;
      3'd4, 3'd5: begin
        for (int i = 0; i < 3; i++) dst[i] = 3 + i;
        for (int i = 3; i < 7; i++) dst[i] = 9 + i;
      end
      default: for (int i = 0; i < 10; i++) dst[i] = 6 + i;
    endcase
    for (int i = 0; i < 16; i++) if (dst[i] >= 0) w[dst[i]] = imm[i];
    return w;
  endfunction

  task automatic model_clear();
    q.delete();
    m_enc    = 0;
    m_err    = 0;
    m_sticky = 1'b0;
    m_rdy    = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [15:0] exp_instr;
    logic        exp_rerr;
    exp_instr = (q.size() > 0) ? q[0][16:1] : 16'h0000;
    exp_rerr  = (q.size() > 0) ? q[0][0] : 1'b0;
    check_eq("in_ready",  in_ready,  m_rdy && (q.size() < 2));
    check_eq("out_valid", out_valid, q.size() > 0);
    check_eq("out_instr", out_instr, exp_instr);
    check_eq("out_range_err", out_range_err, exp_rerr);
    check_eq("enc_count", enc_count, m_enc);
    check_eq("err_count", err_count, m_err);
    check_eq("err_sticky", err_sticky, m_sticky);
  endtask

  // One clock: compare at the negedge, drive, advance the model at the posedge
  task automatic cycle(input bit v, input logic [15:0] f, input logic [15:0] imm,
                       input bit ordy, input bit clr);
    bit acc;
    bit pp;
    bit e;
    compare_outputs();
    in_valid  = v;
    in_fields = f;
    in_imm    = imm;
    out_ready = ordy;
    clr_err   = clr;
    acc = v && m_rdy && (q.size() < 2);
    pp  = (q.size() > 0) && ordy;
    e   = CHK_EN && ref_err(f, imm);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back({ref_encode(f, imm), e});
    if (acc) m_enc = (m_enc + 1) % (1 << CNT_W);
    if (CHK_EN) begin
      if (clr) begin
        m_err    = (acc && e) ? 1 : 0;
        m_sticky = acc && e;
      end else if (acc && e) begin
        m_err    = (m_err < 255) ? m_err + 1 : 255;
        m_sticky = 1'b1;
      end
    end
    m_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 16'h0000, 16'h0000, ordy, 1'b0);
  endtask

  initial begin
    logic [15:0] f;
    logic [15:0] imm;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_fields = '0;
    in_imm    = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    model_clear();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    compare_outputs();
    check_eq("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    idle(1'b1);
    check_eq("rdy_after_rst", in_ready, 1'b1);

    // Opcode 000, -3
    cycle(1'b1, 16'h0000, 16'hFFFD, 1'b1, 1'b0);
    check_eq("s033_valid", out_valid, 1'b1);
    check_eq("s033_instr", out_instr, 16'hD000);
    check_eq("s033_rerr", out_range_err, 1'b0);
    idle(1'b1);

    // Opcode 001, +37 (out of range, truncated)
    cycle(1'b1, 16'h4001, 16'h0025, 1'b1, 1'b0);
    check_eq("s034_instr", out_instr, 16'hCA01);
    check_eq("s034_rerr", out_range_err, CHK_EN);
    check_eq("s034_errcnt", err_count, CHK_EN ? 1 : 0);
    check_eq("s034_sticky", err_sticky, CHK_EN);
    idle(1'b1);

    // Opcode 100, -59 (split field)
    cycle(1'b1, 16'h0004, 16'hFFC5, 1'b1, 1'b0);
    check_eq("s035_rerr", out_range_err, 1'b0);
    idle(1'b1);

    // Back-pressure: three requests, only two fit; head must hold
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom_range(0, 40)), 1'b0, 1'b0);
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Error-count saturation, then clear colliding with an error
    for (int i = 0; i < 260; i++) cycle(1'b1, 16'h0003, 16'h0001, 1'b1, 1'b0);
    check_eq("sat_errcnt", err_count, CHK_EN ? 255 : 0);
    cycle(1'b1, 16'h0003, 16'h0001, 1'b1, 1'b1);
    check_eq("clr_with_err", err_count, CHK_EN ? 1 : 0);
    check_eq("clr_with_err_sticky", err_sticky, CHK_EN);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    check_eq("clr_only", err_count, 0);
    idle(1'b1);

    // Reset with two entries queued
    cycle(1'b1, 16'h0006, 16'h0123, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 16'h0007, 1'b0, 1'b0);
    check_eq("pre_rst_full", in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_enc", enc_count, 0);
    check_eq("midrst_instr", out_instr, 0);
    check_eq("midrst_ready", in_ready, 1'b0);
    model_clear();
    in_valid = 1'b0;
    @(negedge clk);
    compare_outputs();
    reset = 1'b0;
    idle(1'b1);
    cycle(1'b1, 16'h0000, 16'hFFFD, 1'b1, 1'b0);
    check_eq("post_rst_instr", out_instr, 16'hD000);
    check_eq("post_rst_enc", enc_count, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      f   = 16'($urandom);
      imm = ($urandom_range(0, 1) == 1) ? 16'(int'($urandom_range(0, 1200)) - 600)
                                        : 16'($urandom);
      cycle($urandom_range(0, 3) != 0, f, imm, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
